// File: rtl/hpi_txn_sequencer.sv
// Two-port round-robin sequencer for single-word CY7C67200 HPI transactions.
// A granted request walks SETUP -> STROBE -> HOLD -> RECOVER with per-phase cycle counts.
module hpi_txn_sequencer #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,

  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,

  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,

  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in,

  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD    = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD   = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD     = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVERY_LD = 4'(RECOVERY_CYC - 1);

  state_t      state_q, state_nx;
  logic [3:0]  cnt_q, cnt_nx;
  logic        last_grant_q;
  logic        txn_port_q;
  logic        txn_write_q;
  logic [1:0]  txn_addr_q;
  logic [15:0] txn_wdata_q;

  logic        grant0, grant1;
  logic        accept;
  logic        cnt_done;
  logic        strobe_last;
  logic        sel_write;
  logic [1:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic        write_nx;
  logic        active_nx;

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    grant0      = req0_valid && (!req1_valid || last_grant_q);
    grant1      = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready  = (state_q == ST_IDLE) && grant0;
    req1_ready  = (state_q == ST_IDLE) && grant1;
    accept      = req0_ready || req1_ready;

    sel_write   = req1_ready ? req1_write : req0_write;
    sel_addr    = req1_ready ? req1_addr  : req0_addr;
    sel_wdata   = req1_ready ? req1_wdata : req0_wdata;

    cnt_done    = (cnt_q == 4'd0);
    strobe_last = (state_q == ST_STROBE) && cnt_done;

    state_nx    = state_q;
    cnt_nx      = cnt_done ? 4'd0 : cnt_q - 4'd1;

    case (state_q)
      ST_IDLE: begin
        cnt_nx = 4'd0;
        if (accept) begin
          state_nx = ST_SETUP;
          cnt_nx   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_nx = ST_STROBE;
          cnt_nx   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (cnt_done) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_nx = ST_RECOVER;
          cnt_nx   = RECOVERY_LD;
        end
      end
      ST_RECOVER: begin
        if (cnt_done) begin
          state_nx = ST_IDLE;
          cnt_nx   = 4'd0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase

    write_nx  = accept ? sel_write : txn_write_q;
    active_nx = (state_nx == ST_SETUP) || (state_nx == ST_STROBE) || (state_nx == ST_HOLD);
  end

  // Pad controls are registered from the next state so the pins never glitch
  // on state decode; reset drops them at the very edge that aborts a transfer.
  // NOTE: synchronous reset is sampled inside the clocked block; every state
  // register uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      txn_port_q   <= 1'b0;
      txn_write_q  <= 1'b0;
      txn_addr_q   <= 2'd0;
      txn_wdata_q  <= 16'd0;
      hpi_cs_n     <= 1'b1;
      hpi_rd_n     <= 1'b1;
      hpi_wr_n     <= 1'b1;
      hpi_data_oe  <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= 16'd0;
      rsp1_rdata   <= 16'd0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;

      if (accept) begin
        last_grant_q <= req1_ready;
        txn_port_q   <= req1_ready;
        txn_write_q  <= sel_write;
        txn_addr_q   <= sel_addr;
        txn_wdata_q  <= sel_wdata;
      end

      hpi_cs_n    <= !active_nx;
      hpi_rd_n    <= !((state_nx == ST_STROBE) && !write_nx);
      hpi_wr_n    <= !((state_nx == ST_STROBE) && write_nx);
      hpi_data_oe <= active_nx && write_nx;

      rsp0_valid <= strobe_last && !txn_port_q;
      rsp1_valid <= strobe_last && txn_port_q;

      // Read data lands on the final strobe edge; writes leave rdata untouched.
      if (strobe_last && !txn_write_q) begin
        if (txn_port_q) rsp1_rdata <= hpi_data_in;
        else            rsp0_rdata <= hpi_data_in;
      end
    end
  end

  // Address and write data come straight from the capture flops, so they stay
  // put through RECOVER and until the next grant.
  assign hpi_addr     = txn_addr_q;
  assign hpi_data_out = txn_wdata_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// Directed bench for hpi_txn_sequencer: default-timing instance plus a second
// instance with SETUP 3 / STROBE 1 / HOLD 2 / RECOVERY 1 sharing the same inputs.
module tb_hpi_txn_sequencer;

  logic        clk_clk;
  logic        reset_reset_n;
  logic        req0_valid, req0_write;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_write;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic [15:0] hpi_data_in;

  logic        req0_ready, rsp0_valid, req1_ready, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe, busy;
  logic [15:0] hpi_data_out;

  logic        p_req0_ready, p_rsp0_valid, p_req1_ready, p_rsp1_valid;
  logic [15:0] p_rsp0_rdata, p_rsp1_rdata;
  logic [1:0]  p_hpi_addr;
  logic        p_hpi_cs_n, p_hpi_rd_n, p_hpi_wr_n, p_hpi_data_oe, p_busy;
  logic [15:0] p_hpi_data_out;

  int tests_run;
  int tests_failed;

  // Per-cycle traces, index 0 = the cycle the trace starts in.
  logic        tr_ready0 [0:63];
  logic        tr_ready1 [0:63];
  logic        tr_cs     [0:63];
  logic        tr_rd     [0:63];
  logic        tr_wr     [0:63];
  logic        tr_oe     [0:63];
  logic        tr_rsp0   [0:63];
  logic        tr_rsp1   [0:63];
  logic        tr_busy   [0:63];
  logic [1:0]  tr_addr   [0:63];
  logic [15:0] tr_dout   [0:63];
  logic [15:0] tr_rdata0 [0:63];
  logic [15:0] tr_rdata1 [0:63];
  logic        tp_ready0 [0:63];
  logic        tp_cs     [0:63];
  logic        tp_rd     [0:63];
  logic        tp_rsp0   [0:63];
  logic        tp_busy   [0:63];

  hpi_txn_sequencer dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n), .hpi_wr_n(hpi_wr_n),
    .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe), .hpi_data_in(hpi_data_in),
    .busy(busy)
  );

  hpi_txn_sequencer #(
    .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVERY_CYC(1)
  ) dut_p (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(p_req0_ready),
    .rsp0_valid(p_rsp0_valid), .rsp0_rdata(p_rsp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(p_req1_ready),
    .rsp1_valid(p_rsp1_valid), .rsp1_rdata(p_rsp1_rdata),
    .hpi_addr(p_hpi_addr), .hpi_cs_n(p_hpi_cs_n), .hpi_rd_n(p_hpi_rd_n), .hpi_wr_n(p_hpi_wr_n),
    .hpi_data_out(p_hpi_data_out), .hpi_data_oe(p_hpi_data_oe), .hpi_data_in(hpi_data_in),
    .busy(p_busy)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic do_reset();
    reset_reset_n = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 2'd0; req0_wdata = 16'd0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 2'd0; req1_wdata = 16'd0;
    hpi_data_in = 16'd0;
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
  endtask

  // Samples both instances on each falling edge, starting in the current cycle.
  task automatic trace(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_clk);
      tr_ready0[i] = req0_ready;   tr_ready1[i] = req1_ready;
      tr_cs[i]     = hpi_cs_n;     tr_rd[i]     = hpi_rd_n;
      tr_wr[i]     = hpi_wr_n;     tr_oe[i]     = hpi_data_oe;
      tr_rsp0[i]   = rsp0_valid;   tr_rsp1[i]   = rsp1_valid;
      tr_busy[i]   = busy;         tr_addr[i]   = hpi_addr;
      tr_dout[i]   = hpi_data_out;
      tr_rdata0[i] = rsp0_rdata;   tr_rdata1[i] = rsp1_rdata;
      tp_ready0[i] = p_req0_ready; tp_cs[i]     = p_hpi_cs_n;
      tp_rd[i]     = p_hpi_rd_n;   tp_rsp0[i]   = p_rsp0_valid;
      tp_busy[i]   = p_busy;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || p_busy) && n < 50) begin
      @(negedge clk_clk);
      n++;
    end
    tests_run++;
    if (busy || p_busy) begin
      tests_failed++;
      $display("FAIL %s idle_timeout busy=%b p_busy=%b after %0d cycles", name, busy, p_busy, n);
    end
    @(posedge clk_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] obs_ctl, exp_ctl;
    logic [65:0] obs_dat;
    do_reset();
    @(negedge clk_clk);
    obs_ctl = {hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe, busy, rsp0_valid, rsp1_valid,
               req0_ready, req1_ready, p_hpi_cs_n, p_hpi_rd_n, p_hpi_wr_n, p_hpi_data_oe,
               p_busy, p_rsp1_valid, p_req1_ready};
    exp_ctl = 16'b1110_0000_0111_0000;
    tests_run++;
    if (obs_ctl !== exp_ctl) begin
      tests_failed++;
      $display("FAIL reset_ctl got %b exp %b", obs_ctl, exp_ctl);
    end
    obs_dat = {hpi_addr, hpi_data_out, rsp0_rdata, rsp1_rdata, p_hpi_data_out};
    tests_run++;
    if (obs_dat !== 66'd0) begin
      tests_failed++;
      $display("FAIL reset_data got %h exp 0", obs_dat);
    end
    tests_run++;
    if ({p_hpi_addr, p_rsp0_rdata, p_rsp1_rdata} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_data_p got %h exp 0", {p_hpi_addr, p_rsp0_rdata, p_rsp1_rdata});
    end
  endtask

  task automatic test_single_read();
    logic [7:0] obs, exp;
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd3; req0_wdata = 16'hFFFF;
    hpi_data_in = 16'hA55A;
    fork
      trace(10);
      begin @(posedge clk_clk); #1 req0_valid = 1'b0; end
    join
    for (int i = 0; i < 10; i++) begin
      obs = {tr_cs[i], tr_rd[i], tr_wr[i], tr_oe[i], tr_rsp0[i], tr_rsp1[i], tr_busy[i], tr_ready0[i]};
      exp = {!(i >= 1 && i <= 6), !(i >= 2 && i <= 5), 1'b1, 1'b0,
             (i == 6), 1'b0, (i >= 1 && i <= 8), (i == 0)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL read_cycle T0+%0d got cs,rd,wr,oe,rsp0,rsp1,busy,rdy0=%b exp %b", i, obs, exp);
      end
    end
    tests_run++;
    if (tr_rdata0[6] !== 16'hA55A) begin
      tests_failed++;
      $display("FAIL read_rdata got %h exp a55a", tr_rdata0[6]);
    end
    tests_run++;
    if (tr_addr[3] !== 2'd3) begin
      tests_failed++;
      $display("FAIL read_addr got %0d exp 3", tr_addr[3]);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] obs, exp;
    @(posedge clk_clk); #1;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 2'd2; req1_wdata = 16'h1234;
    hpi_data_in = 16'hBEEF;
    fork
      trace(10);
      begin @(posedge clk_clk); #1 req1_valid = 1'b0; end
    join
    for (int i = 0; i < 10; i++) begin
      obs = {tr_cs[i], tr_rd[i], tr_wr[i], tr_oe[i], tr_rsp0[i], tr_rsp1[i], tr_busy[i], tr_ready1[i]};
      exp = {!(i >= 1 && i <= 6), 1'b1, !(i >= 2 && i <= 5), (i >= 1 && i <= 6),
             1'b0, (i == 6), (i >= 1 && i <= 8), (i == 0)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL write_cycle T0+%0d got cs,rd,wr,oe,rsp0,rsp1,busy,rdy1=%b exp %b", i, obs, exp);
      end
      if (i >= 1 && i <= 6) begin
        tests_run++;
        if (tr_dout[i] !== 16'h1234 || tr_addr[i] !== 2'd2) begin
          tests_failed++;
          $display("FAIL write_bus T0+%0d got data %h addr %0d exp 1234 addr 2", i, tr_dout[i], tr_addr[i]);
        end
      end
    end
    tests_run++;
    if (tr_rdata1[9] !== 16'h0000 || tr_rdata0[9] !== 16'hA55A) begin
      tests_failed++;
      $display("FAIL write_rdata_kept got rdata1 %h rdata0 %h exp 0000 a55a", tr_rdata1[9], tr_rdata0[9]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs, exp;
    int k;
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd1;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 2'd0; req1_wdata = 16'h5A5A;
    trace(36);
    @(posedge clk_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 36; i++) begin
      k = i % 18;
      obs = {tr_ready0[i], tr_ready1[i], tr_rsp0[i], tr_rsp1[i], tr_rd[i], tr_wr[i]};
      exp = {(k == 0), (k == 9), (k == 6), (k == 15), !(k >= 2 && k <= 5), !(k >= 11 && k <= 14)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL contention T0+%0d got rdy0,rdy1,rsp0,rsp1,rd,wr=%b exp %b", i, obs, exp);
      end
    end
    wait_idle("contention");
  endtask

  task automatic test_param_sweep();
    logic [4:0] obs, exp;
    int k;
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd0;
    trace(12);
    @(posedge clk_clk); #1 req0_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      k = i % 8;
      obs = {tp_ready0[i], tp_cs[i], tp_rd[i], tp_rsp0[i], tp_busy[i]};
      exp = {(k == 0), !(k >= 1 && k <= 6), (k != 4), (k == 5), (k >= 1 && k <= 7)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL param_cycle T0+%0d got rdy0,cs,rd,rsp0,busy=%b exp %b", i, obs, exp);
      end
    end
    wait_idle("param_sweep");
  endtask

  task automatic test_reset_mid_strobe();
    logic [3:0] obs, exp;
    do_reset();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd1;
    req1_valid = 1'b0;
    fork
      trace(9);
      begin
        @(posedge clk_clk); #1 req0_valid = 1'b0;
        @(posedge clk_clk); #1;
        @(posedge clk_clk); #1 reset_reset_n = 1'b0;
        @(posedge clk_clk); #1 reset_reset_n = 1'b1;
      end
    join
    for (int i = 0; i < 9; i++) begin
      obs = {tr_cs[i], tr_rd[i], tr_rsp0[i], tr_busy[i]};
      exp = {!(i >= 1 && i <= 3), !(i >= 2 && i <= 3), 1'b0, (i >= 1 && i <= 3)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL abort_cycle T0+%0d got cs,rd,rsp0,busy=%b exp %b", i, obs, exp);
      end
    end
    @(posedge clk_clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; req1_write = 1'b0;
    @(negedge clk_clk);
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL abort_first_grant got rdy0,rdy1=%b exp 10", {req0_ready, req1_ready});
    end
    @(posedge clk_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("reset_mid_strobe");
  endtask

  task automatic test_withdrawn();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd2;
    req1_write = 1'b1; req1_addr = 2'd3; req1_wdata = 16'hC0DE;
    fork
      trace(21);
      begin
        @(posedge clk_clk); #1 req0_valid = 1'b0;
        @(posedge clk_clk); #1 req1_valid = 1'b1;
        @(posedge clk_clk); #1 req1_valid = 1'b0;
      end
    join
    for (int i = 0; i < 21; i++) begin
      tests_run++;
      if (tr_ready1[i] !== 1'b0 || tr_rsp1[i] !== 1'b0 || tr_wr[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL withdrawn_port1 T0+%0d got rdy1,rsp1,wr=%b%b%b exp 001", i, tr_ready1[i], tr_rsp1[i], tr_wr[i]);
      end
      if (i >= 9) begin
        tests_run++;
        if (tr_cs[i] !== 1'b1 || tr_busy[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL withdrawn_idle T0+%0d got cs,busy=%b%b exp 10", i, tr_cs[i], tr_busy[i]);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_param_sweep();
    test_reset_mid_strobe();
    test_withdrawn();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hpi_txn_sequencer.md
Name: hpi_txn_sequencer

Overview:
- Sequences single-word transactions on the CY7C67200 OTG Host Port Interface: 2-bit address, 16-bit data, chip select and read/write strobes.
- Two requesters share the one HPI bus:
  - port 0: the NIOS-side software path.
  - port 1: the hardware keycode poller.
- A round-robin arbiter picks between them; a timed setup/strobe/hold/recovery FSM then drives the bus.
- Sits between the SoC fabric and the top-level HPI pins/tristate buffer.

Parameters:
- SETUP_CYC, 1, cycles with cs_n low and address/data stable before the strobe (1..15)
- STROBE_CYC, 4, cycles rd_n/wr_n held low (1..15)
- HOLD_CYC, 1, cycles cs_n low after the strobe rises (1..15)
- RECOVERY_CYC, 2, cycles cs_n high before the next grant (1..15)

Ports:
- clk_clk  in  1  system clock; single clock domain
- reset_reset_n  in  1  synchronous, active-low reset
- req0_valid  in  1  port 0 request; fields below held stable until accepted
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
- req0_wdata  in  16  write data
- req0_ready  out  1  accept pulse; transaction captured on this edge
- rsp0_valid  out  1  one-cycle completion pulse (read and write)
- rsp0_rdata  out  16  read data, valid with rsp0_valid
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1
- hpi_addr  out  2  to HPI A[1:0]
- hpi_cs_n  out  1  chip select, active low
- hpi_rd_n  out  1  read strobe, active low
- hpi_wr_n  out  1  write strobe, active low
- hpi_data_out  out  16  write data to pad
- hpi_data_oe  out  1  pad output enable
- hpi_data_in  in  16  pad input data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (synchronous, takes effect at the next edge):
  - hpi_cs_n = hpi_rd_n = hpi_wr_n = 1; hpi_data_oe = 0; hpi_addr = 0; hpi_data_out = 0.
  - All ready and rsp_valid = 0; rsp_rdata = 0; busy = 0; state = IDLE; last_grant = 1, so port 0 wins first.
- Reset during a transaction aborts it: strobes rise at the next edge and no rsp is issued.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. A 4-bit down-counter is loaded on each state entry.
- IDLE arbitration:
  - Only one valid: grant that port.
  - Both valid: grant the port that is not last_grant.
  - reqN_ready = (state == IDLE) && granted N. It is combinational, at most one port per cycle.
  - On the ready edge: capture write, addr, wdata and port id; update last_grant; go to SETUP.
- A valid that drops before ready starts no transaction.
- Cycle timing, with T0 = the ready cycle and S/T/H/R = the parameters:
  - SETUP, cycles T0+1..T0+S: cs_n = 0, hpi_addr driven; hpi_data_oe = 1 and hpi_data_out = wdata if write.
  - STROBE, next T cycles: rd_n = 0 (read) or wr_n = 0 (write). Read data is registered from hpi_data_in on the last STROBE cycle's edge.
  - HOLD, next H cycles: strobes = 1; cs_n, addr and oe/data unchanged.
  - rspN_valid pulses in the first HOLD cycle (T0+S+T+1). rsp_rdata is updated for reads and keeps its previous value for writes.
  - RECOVER, next R cycles: cs_n = 1, oe = 0, addr held.
  - IDLE is re-entered at T0+S+T+H+R+1.
  - Defaults: occupancy 9 cycles; back-to-back grants are 9 cycles apart.
- Strobe exclusivity: rd_n and wr_n are never low together, and never low while cs_n = 1.
- Only the granted port's rsp_valid pulses; the other port's rsp outputs stay unchanged.
- New requests arriving during a transaction wait. They are arbitrated in the next IDLE cycle.

Test Plan:
- Single read: req0 read addr 3 at T0, hpi_data_in = 16'hA55A during STROBE -> cs_n low T0+1..T0+6; rd_n low T0+2..T0+5; rsp0_valid at T0+6 with rdata 16'hA55A; busy low at T0+9.
- Single write: req1 write addr 2 wdata 16'h1234 -> hpi_data_oe = 1 and data_out = 16'h1234 for T0+1..T0+6; wr_n low T0+2..T0+5; rd_n stays high; rsp1_valid at T0+6.
- Contention: req0 and req1 both valid from reset -> grants alternate 0,1,0,1 at 9-cycle spacing; each rsp goes only to its own port.
- Parameter sweep: SETUP 3, STROBE 1, HOLD 2, RECOVERY 1 -> strobe one cycle wide; rsp at T0+5; next grant at T0+8.
- Reset mid-STROBE: reset_reset_n low in cycle T0+3 -> strobes and cs_n high at the next edge; no rsp; after release port 0 is granted first.
- Withdrawn request: req1_valid pulses for one cycle while busy, then drops -> no grant and no HPI activity for port 1.
